// File: rtl/instr_fetch_seq_if.sv
// Instruction-fetch memory handshake: req/ack with address out and read data back.
// The sequencer takes the master side; the instruction memory takes the slave side.
interface instr_fetch_seq_if #(
    parameter int XLEN = 32
);
    logic            mem_req;
    logic [XLEN-1:0] mem_addr;
    logic            mem_ack;
    logic [XLEN-1:0] mem_rdata;

    modport master (
        output mem_req,
        output mem_addr,
        input  mem_ack,
        input  mem_rdata
    );

    modport slave (
        input  mem_req,
        input  mem_addr,
        output mem_ack,
        output mem_rdata
    );
endinterface

// File: rtl/instr_fetch_seq.sv
// Single-issue fetch/decode sequencer driving the OP-IMM and OP execute-unit enables.
// Optional macro FETCH_TIMEOUT_EN adds a fetch-wait limit that raises fetch_fault and halts.
module instr_fetch_seq #(
    parameter int              XLEN           = 32,
    parameter logic [XLEN-1:0] RESET_PC       = '0,
    parameter int              EXEC_CYCLES    = 2,
    parameter int              TIMEOUT_CYCLES = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 run,
    instr_fetch_seq_if.master    mem,
    output logic [XLEN-1:0]      instruction,
    output logic [XLEN-1:0]      pc,
    output logic                 alu_imm_enable_n,
    output logic                 alu_reg_enable_n,
    output logic                 illegal,
    output logic                 fetch_fault,
    output logic                 halted
);

    localparam logic [XLEN-1:0] NOP       = XLEN'(32'h0000_0013);
    localparam logic [6:0]      OPC_IMM   = 7'b0010011;
    localparam logic [6:0]      OPC_REG   = 7'b0110011;
    localparam int              EW        = (EXEC_CYCLES > 1) ? $clog2(EXEC_CYCLES) : 1;
    localparam logic [EW-1:0]   EXEC_LAST = EW'(EXEC_CYCLES - 1);

    if (EXEC_CYCLES < 2 || TIMEOUT_CYCLES < 1 || RESET_PC[1:0] != 2'b00) begin : g_bad_param
        $error("instr_fetch_seq: EXEC_CYCLES>=2, TIMEOUT_CYCLES>=1 and aligned RESET_PC required");
    end

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        EXEC   = 3'd3,
        HALT   = 3'd4
    } state_t;

    state_t          state, state_nxt;
    logic [XLEN-1:0] pc_nxt, addr_nxt, instr_nxt;
    logic            req_nxt, imm_n_nxt, reg_n_nxt, illegal_nxt, halted_nxt;
    logic [EW-1:0]   exec_cnt, exec_cnt_nxt;

`ifdef FETCH_TIMEOUT_EN
    localparam int            WW        = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [WW-1:0] WAIT_LAST = WW'(TIMEOUT_CYCLES - 1);
    logic [WW-1:0] wait_cnt, wait_cnt_nxt;
    logic          fault_nxt;
`endif

    // Every output is registered; this block computes all next values with hold as the default.
    always_comb begin
        state_nxt    = state;
        pc_nxt       = pc;
        req_nxt      = mem.mem_req;
        addr_nxt     = mem.mem_addr;
        instr_nxt    = instruction;
        imm_n_nxt    = alu_imm_enable_n;
        reg_n_nxt    = alu_reg_enable_n;
        illegal_nxt  = illegal;
        halted_nxt   = halted;
        exec_cnt_nxt = exec_cnt;
`ifdef FETCH_TIMEOUT_EN
        wait_cnt_nxt = wait_cnt;
        fault_nxt    = fetch_fault;
`endif
        case (state)
            IDLE: begin
                if (run) begin
                    state_nxt = FETCH;
                    req_nxt   = 1'b1;
                    addr_nxt  = pc;
`ifdef FETCH_TIMEOUT_EN
                    wait_cnt_nxt = '0;
`endif
                end
            end
            FETCH: begin
                // An ack always wins over a timeout landing on the same cycle.
                if (mem.mem_ack) begin
                    instr_nxt = mem.mem_rdata;
                    req_nxt   = 1'b0;
                    state_nxt = DECODE;
                end
`ifdef FETCH_TIMEOUT_EN
                else if (wait_cnt == WAIT_LAST) begin
                    fault_nxt  = 1'b1;
                    halted_nxt = 1'b1;
                    req_nxt    = 1'b0;
                    state_nxt  = HALT;
                end else begin
                    wait_cnt_nxt = wait_cnt + 1'b1;
                end
`endif
            end
            DECODE: begin
                exec_cnt_nxt = '0;
                case (instruction[6:0])
                    OPC_IMM: begin
                        imm_n_nxt = 1'b0;
                        state_nxt = EXEC;
                    end
                    OPC_REG: begin
                        reg_n_nxt = 1'b0;
                        state_nxt = EXEC;
                    end
                    default: begin
                        illegal_nxt = 1'b1;
                        halted_nxt  = 1'b1;
                        state_nxt   = HALT;
                    end
                endcase
            end
            EXEC: begin
                if (exec_cnt == EXEC_LAST) begin
                    imm_n_nxt = 1'b1;
                    reg_n_nxt = 1'b1;
                    pc_nxt    = pc + XLEN'(4);
                    if (run) begin
                        state_nxt = FETCH;
                        req_nxt   = 1'b1;
                        addr_nxt  = pc + XLEN'(4);
`ifdef FETCH_TIMEOUT_EN
                        wait_cnt_nxt = '0;
`endif
                    end else begin
                        state_nxt = IDLE;
                    end
                end else begin
                    exec_cnt_nxt = exec_cnt + 1'b1;
                end
            end
            HALT: begin
                halted_nxt = 1'b1;
                req_nxt    = 1'b0;
                imm_n_nxt  = 1'b1;
                reg_n_nxt  = 1'b1;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= IDLE;
            pc               <= RESET_PC;
            mem.mem_req      <= 1'b0;
            mem.mem_addr     <= '0;
            instruction      <= NOP;
            alu_imm_enable_n <= 1'b1;
            alu_reg_enable_n <= 1'b1;
            illegal          <= 1'b0;
            halted           <= 1'b0;
            exec_cnt         <= '0;
        end else begin
            state            <= state_nxt;
            pc               <= pc_nxt;
            mem.mem_req      <= req_nxt;
            mem.mem_addr     <= addr_nxt;
            instruction      <= instr_nxt;
            alu_imm_enable_n <= imm_n_nxt;
            alu_reg_enable_n <= reg_n_nxt;
            illegal          <= illegal_nxt;
            halted           <= halted_nxt;
            exec_cnt         <= exec_cnt_nxt;
        end
    end

`ifdef FETCH_TIMEOUT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt    <= '0;
            fetch_fault <= 1'b0;
        end else begin
            wait_cnt    <= wait_cnt_nxt;
            fetch_fault <= fault_nxt;
        end
    end
`else
    assign fetch_fault = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch_seq.sv
// Directed bench for instr_fetch_seq: two instances (RESET_PC 0 and 0xFFFF_FFFC) on one clock.
module tb_instr_fetch_seq;

    logic clk = 1'b0;
    logic rst;
    logic run_a, run_b;

    always #5 clk = ~clk;

    instr_fetch_seq_if #(.XLEN(32)) if_a ();
    instr_fetch_seq_if #(.XLEN(32)) if_b ();

    logic [31:0] instr_a, pc_a, instr_b, pc_b;
    logic        imm_a, reg_a, ill_a, ff_a, halt_a;
    logic        imm_b, reg_b, ill_b, ff_b, halt_b;

    instr_fetch_seq #(
        .XLEN(32), .RESET_PC(32'h0000_0000), .EXEC_CYCLES(2), .TIMEOUT_CYCLES(16)
    ) dut_a (
        .clk(clk), .rst(rst), .run(run_a), .mem(if_a.master),
        .instruction(instr_a), .pc(pc_a),
        .alu_imm_enable_n(imm_a), .alu_reg_enable_n(reg_a),
        .illegal(ill_a), .fetch_fault(ff_a), .halted(halt_a)
    );

    instr_fetch_seq #(
        .XLEN(32), .RESET_PC(32'hFFFF_FFFC), .EXEC_CYCLES(2), .TIMEOUT_CYCLES(16)
    ) dut_b (
        .clk(clk), .rst(rst), .run(run_b), .mem(if_b.master),
        .instruction(instr_b), .pc(pc_b),
        .alu_imm_enable_n(imm_b), .alu_reg_enable_n(reg_b),
        .illegal(ill_b), .fetch_fault(ff_b), .halted(halt_b)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        run_a = 1'b0; run_b = 1'b0;
        if_a.mem_ack = 1'b0; if_a.mem_rdata = '0;
        if_b.mem_ack = 1'b0; if_b.mem_rdata = '0;
        cyc(2);

        // reset values
        chk("rst_req",   32'(if_a.mem_req), 32'd0);
        chk("rst_addr",  if_a.mem_addr, 32'h0);
        chk("rst_pc",    pc_a, 32'h0);
        chk("rst_instr", instr_a, 32'h0000_0013);
        chk("rst_imm",   32'(imm_a), 32'd1);
        chk("rst_reg",   32'(reg_a), 32'd1);
        chk("rst_ill",   32'(ill_a), 32'd0);
        chk("rst_ff",    32'(ff_a), 32'd0);
        chk("rst_halt",  32'(halt_a), 32'd0);
        chk("rst_pc_b",  pc_b, 32'hFFFF_FFFC);

        // test 1: OP-IMM with zero-wait memory (ack held high, ignored outside FETCH)
        rst = 1'b0; run_a = 1'b1;
        if_a.mem_ack = 1'b1; if_a.mem_rdata = 32'h0050_0093;
        cyc();
        chk("t1_req",       32'(if_a.mem_req), 32'd1);
        chk("t1_addr",      if_a.mem_addr, 32'h0);
        chk("t1_instr_old", instr_a, 32'h0000_0013);
        cyc();
        chk("t1_instr",     instr_a, 32'h0050_0093);
        chk("t1_req_off",   32'(if_a.mem_req), 32'd0);
        chk("t1_imm_dec",   32'(imm_a), 32'd1);
        cyc();
        chk("t1_imm_lo0",   32'(imm_a), 32'd0);
        chk("t1_reg_hi",    32'(reg_a), 32'd1);
        cyc();
        chk("t1_imm_lo1",   32'(imm_a), 32'd0);
        chk("t1_pc_hold",   pc_a, 32'h0);
        if_a.mem_rdata = 32'h0020_81B3;
        cyc();
        chk("t1_imm_hi",    32'(imm_a), 32'd1);
        chk("t1_pc4",       pc_a, 32'h4);
        chk("t1_req2",      32'(if_a.mem_req), 32'd1);
        chk("t1_addr4",     if_a.mem_addr, 32'h4);

        // test 2: OP register-register
        cyc();
        chk("t2_instr",     instr_a, 32'h0020_81B3);
        cyc();
        chk("t2_reg_lo0",   32'(reg_a), 32'd0);
        chk("t2_imm_hi",    32'(imm_a), 32'd1);
        cyc();
        chk("t2_reg_lo1",   32'(reg_a), 32'd0);
        if_a.mem_ack = 1'b0; if_a.mem_rdata = 32'h0010_0113;
        cyc();
        chk("t2_reg_hi",    32'(reg_a), 32'd1);
        chk("t2_pc8",       pc_a, 32'h8);
        chk("t2_addr8",     if_a.mem_addr, 32'h8);

        // test 3: ack delayed five cycles
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk("t3_req_hold",   32'(if_a.mem_req), 32'd1);
            chk("t3_addr_hold",  if_a.mem_addr, 32'h8);
            chk("t3_instr_hold", instr_a, 32'h0020_81B3);
        end
        if_a.mem_ack = 1'b1;
        cyc();
        chk("t3_instr",     instr_a, 32'h0010_0113);
        chk("t3_req_off",   32'(if_a.mem_req), 32'd0);
        if_a.mem_ack = 1'b0;
        cyc();
        chk("t3_imm_lo",    32'(imm_a), 32'd0);
        run_a = 1'b0;
        cyc();
        chk("t3_imm_lo1",   32'(imm_a), 32'd0);
        cyc();
        chk("t3_imm_hi",    32'(imm_a), 32'd1);
        chk("t3_pc12",      pc_a, 32'hC);
        chk("t3_stop_req",  32'(if_a.mem_req), 32'd0);
        cyc(2);
        chk("t3_idle_req",  32'(if_a.mem_req), 32'd0);
        chk("t3_idle_pc",   pc_a, 32'hC);

        // test 4: illegal opcode halts until reset
        if_a.mem_rdata = 32'h0000_006F; if_a.mem_ack = 1'b1; run_a = 1'b1;
        cyc();
        chk("t4_addr12",    if_a.mem_addr, 32'hC);
        cyc(2);
        chk("t4_ill",       32'(ill_a), 32'd1);
        chk("t4_halt",      32'(halt_a), 32'd1);
        chk("t4_imm",       32'(imm_a), 32'd1);
        chk("t4_reg",       32'(reg_a), 32'd1);
        chk("t4_req",       32'(if_a.mem_req), 32'd0);
        for (int i = 0; i < 6; i++) begin
            run_a = i[0];
            cyc();
            chk("t4_stay_halt", 32'(halt_a), 32'd1);
            chk("t4_stay_req",  32'(if_a.mem_req), 32'd0);
            chk("t4_stay_pc",   pc_a, 32'hC);
        end
        rst = 1'b1;
        #1;
        chk("t4_rst_ill",   32'(ill_a), 32'd0);
        chk("t4_rst_halt",  32'(halt_a), 32'd0);
        chk("t4_rst_pc",    pc_a, 32'h0);
        chk("t4_rst_instr", instr_a, 32'h0000_0013);
        cyc();
        rst = 1'b0;

        // asynchronous reset in the middle of EXEC, then a late ack
        run_a = 1'b1; if_a.mem_ack = 1'b1; if_a.mem_rdata = 32'h0050_0093;
        cyc(3);
        chk("r_exec_imm",   32'(imm_a), 32'd0);
        rst = 1'b1; run_a = 1'b0;
        #1;
        chk("r_imm",        32'(imm_a), 32'd1);
        chk("r_pc",         pc_a, 32'h0);
        chk("r_req",        32'(if_a.mem_req), 32'd0);
        chk("r_addr",       if_a.mem_addr, 32'h0);
        chk("r_instr",      instr_a, 32'h0000_0013);
        cyc();
        rst = 1'b0; if_a.mem_rdata = 32'h0020_81B3;
        cyc(2);
        chk("r_late_ack",   instr_a, 32'h0000_0013);
        chk("r_late_req",   32'(if_a.mem_req), 32'd0);

        // test 5: PC wrap on the second instance
        run_b = 1'b1; if_b.mem_ack = 1'b1; if_b.mem_rdata = 32'h0050_0093;
        cyc();
        chk("t5_req",       32'(if_b.mem_req), 32'd1);
        chk("t5_addr",      if_b.mem_addr, 32'hFFFF_FFFC);
        cyc(2);
        chk("t5_imm_lo",    32'(imm_b), 32'd0);
        run_b = 1'b0;
        cyc(2);
        chk("t5_pc_wrap",   pc_b, 32'h0);
        chk("t5_req_off",   32'(if_b.mem_req), 32'd0);
        chk("t5_imm_hi",    32'(imm_b), 32'd1);
        chk("t5_ill",       32'(ill_b), 32'd0);

`ifdef FETCH_TIMEOUT_EN
        // test 6: timeout after 16 unacknowledged FETCH cycles
        do_reset();
        if_a.mem_ack = 1'b0; run_a = 1'b1;
        cyc(16);
        chk("t6_ff_early",  32'(ff_a), 32'd0);
        chk("t6_req_early", 32'(if_a.mem_req), 32'd1);
        cyc();
        chk("t6_ff",        32'(ff_a), 32'd1);
        chk("t6_halt",      32'(halt_a), 32'd1);
        chk("t6_req",       32'(if_a.mem_req), 32'd0);
        // ack on the 16th FETCH cycle beats the timeout
        do_reset();
        if_a.mem_rdata = 32'h0050_0093; run_a = 1'b1;
        cyc(16);
        if_a.mem_ack = 1'b1;
        cyc();
        chk("t6_ack_ff",    32'(ff_a), 32'd0);
        chk("t6_ack_instr", instr_a, 32'h0050_0093);
        chk("t6_ack_halt",  32'(halt_a), 32'd0);
        chk("t6_ack_req",   32'(if_a.mem_req), 32'd0);
`else
        // without the timeout feature FETCH waits indefinitely
        do_reset();
        if_a.mem_ack = 1'b0; run_a = 1'b1;
        cyc(25);
        chk("t6_noto_ff",   32'(ff_a), 32'd0);
        chk("t6_noto_req",  32'(if_a.mem_req), 32'd1);
        chk("t6_noto_halt", 32'(halt_a), 32'd0);
        chk("t6_noto_addr", if_a.mem_addr, 32'h0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
